vector_ops_pipe: RTL



---
 rtl/vector_ops_pkg.sv | 14 +
 rtl/vector_ops_if.sv | 16 +
 rtl/vector_ops_alu.sv | 34 +++
 rtl/vector_ops_pipe.sv | 77 +++++++
 4 files changed

// File: rtl/vector_ops_pkg.sv
// vector_ops_pkg: opcodes and width helpers shared by the vector_ops pipeline.
package vector_ops_pkg;
  localparam logic [2:0] OP_PASS  = 3'd0;
  localparam logic [2:0] OP_BREV  = 3'd1;
  localparam logic [2:0] OP_HSWAP = 3'd2;
  localparam logic [2:0] OP_ROTL  = 3'd3;
  localparam logic [2:0] OP_ROTR  = 3'd4;
  localparam logic [2:0] OP_POPC  = 3'd5;
  localparam logic [2:0] OP_RAND  = 3'd6;
  localparam logic [2:0] OP_INV   = 3'd7;
  function automatic int popc_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/vector_ops_if.sv
// vector_ops_if: valid/ready input and output streams of the vector_ops pipeline.
interface vector_ops_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_flag;
  logic [2:0]       out_op;
  modport master(output in_valid, in_data, in_op, out_ready,
                 input in_ready, out_valid, out_data, out_flag, out_op);
  modport slave(input in_valid, in_data, in_op, out_ready,
                output in_ready, out_valid, out_data, out_flag, out_op);
endinterface

// File: rtl/vector_ops_alu.sv
// vector_ops_alu: combinational bit-level transform of one operand plus its reduction XOR.
module vector_ops_alu
  import vector_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             flag
);
  localparam int PW = popc_w(WIDTH);
  logic [WIDTH-1:0] brev;
  logic [PW-1:0]    popc;
  always_comb begin
    brev = '0;
    popc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      brev[i] = operand[WIDTH-1-i];
      popc    = popc + PW'(operand[i]);
    end
    case (op)
      OP_PASS:  result = operand;
      OP_BREV:  result = brev;
      OP_HSWAP: result = {operand[WIDTH/2-1:0], operand[WIDTH-1:WIDTH/2]};
      OP_ROTL:  result = {operand[WIDTH-2:0], operand[WIDTH-1]};
      OP_ROTR:  result = {operand[0], operand[WIDTH-1:1]};
      OP_POPC:  result = WIDTH'(popc);
      OP_RAND:  result = {WIDTH{&operand}};
      default:  result = ~operand;
    endcase
    flag = ^operand;
  end
endmodule

// File: rtl/vector_ops_pipe.sv
// vector_ops_pipe: two-stage valid/ready vector transform pipeline with
// a parity accumulator and saturating transfer counter on the output stream.
module vector_ops_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  vector_ops_if.slave      bus,
  input  logic             clr_acc,
  output logic             acc_parity,
  output logic [CNT_W-1:0] sample_cnt
);
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_flag_q, s2_flag_d;
  logic [2:0]       s2_op_q, s2_op_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;
  logic             s1_adv, s2_adv, xfer;
  vector_ops_alu #(.WIDTH(WIDTH)) u_alu (
    .operand(s1_data_q),
    .op     (s1_op_q),
    .result (alu_res),
    .flag   (alu_flag)
  );
  always_comb begin
    s2_adv     = !s2_valid_q || bus.out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    xfer       = s2_valid_q && bus.out_ready;
    s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
    s1_data_d  = (s1_adv && bus.in_valid) ? bus.in_data : s1_data_q;
    s1_op_d    = (s1_adv && bus.in_valid) ? bus.in_op : s1_op_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_data_d  = (s2_adv && s1_valid_q) ? alu_res : s2_data_q;
    s2_flag_d  = (s2_adv && s1_valid_q) ? alu_flag : s2_flag_q;
    s2_op_d    = (s2_adv && s1_valid_q) ? s1_op_q : s2_op_q;
    // a clear in the same cycle as a transfer discards that transfer
    acc_d      = clr_acc ? 1'b0 : xfer ? acc_q ^ s2_flag_q : acc_q;
    cnt_d      = clr_acc ? '0 : (xfer && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_flag_q  <= 1'b0;
      s2_op_q    <= '0;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_flag_q  <= s2_flag_d;
      s2_op_q    <= s2_op_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_flag  = s2_flag_q;
  assign bus.out_op    = s2_op_q;
  assign acc_parity    = acc_q;
  assign sample_cnt    = cnt_q;
endmodule
